alu_mult_seq: RTL and testbench
===============================

ALU_MULT_SEQ -- requirements
Module: alu_mult_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit, reset, asynchronous, active-low.
REQ-003 The block SHALL have port start, input, 1 bit, request a multiply; sampled only in IDLE.
REQ-004 The block SHALL have port a, input, 16 bits, multiplicand, unsigned; sampled with start.
REQ-005 The block SHALL have port b, input, 16 bits, multiplier, unsigned; sampled with start.
REQ-006 The block SHALL have port add_a, output, 16 bits, registered operand A to the downstream 16-bit registered adder.
REQ-007 The block SHALL have port add_b, output, 16 bits, registered operand B to the adder.
REQ-008 The block SHALL have port add_sum, input, 16 bits, adder result; valid one cycle after add_a/add_b are presented (adder latency 1, no carry-out).
REQ-009 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1 bit, single-cycle pulse, product valid.
REQ-011 The block SHALL have port product, output, 32 bits, unsigned a*b; held from done until the next accepted start.

Function
REQ-012 The block SHALL implement the states IDLE, EVAL, ADD, WB, DONE.
REQ-013 In IDLE with start=1, the block SHALL latch M=a, lo=b, hi=0 and count=0, then go to EVAL; product is left unchanged until DONE.
REQ-014 In EVAL with lo[0]=0, the block SHALL shift {hi,lo} right by 1 with zero fill, increment count, and go to DONE if count was 15, else stay in EVAL.
REQ-015 In EVAL with lo[0]=1, the block SHALL register add_a=hi and add_b=M, then go to ADD.
REQ-016 ADD SHALL be a one-cycle wait with add_a/add_b held stable, then go to WB.
REQ-017 In WB the block SHALL compute carry = (add_sum < add_a) as an unsigned compare.
REQ-018 In WB the block SHALL shift {carry,add_sum,lo} right by 1 into {hi,lo} and increment count.
REQ-019 In WB the block SHALL go to DONE if count was 15, else to EVAL.
REQ-020 add_a/add_b SHALL hold their values through WB and SHALL change only in EVAL when lo[0]=1.
REQ-021 In DONE the block SHALL set product={hi,lo} and done=1 for exactly one cycle, then go to IDLE.
REQ-022 Latency SHALL be fixed: done is high in cycle 17+2*popcount(b) after the edge that sampled start.
REQ-023 There SHALL be no early exit for b=0 or a=0.
REQ-024 While busy=1, start SHALL be ignored, and a/b changes SHALL have no effect.
REQ-025 start=1 in the DONE cycle SHALL be ignored; start is accepted in the following IDLE cycle.
REQ-026 Arithmetic SHALL be modulo-free: a 32-bit product is exact for all inputs, and 0xFFFF*0xFFFF=0xFFFE0001.

Reset
REQ-027 When rst=0, the block SHALL asynchronously force state=IDLE, busy=0, done=0, product=0, add_a=0, add_b=0, hi=0, lo=0, M=0, count=0.
REQ-028 Reset asserted mid-operation SHALL abort the multiply with no done pulse; after release the block accepts start normally.
REQ-029 The block SHALL not require the adder's own reset to coincide with its reset, since add_sum is consumed only in WB.

Verification
REQ-030 The bench SHALL cover: a=3, b=4 -> done 19 cycles after start, product=0x0000000C, add_a=0/add_b=3 presented exactly once.
REQ-031 The bench SHALL cover: a=0xFFFF, b=0xFFFF -> done after 49 cycles, product=0xFFFE0001, carry path exercised.
REQ-032 The bench SHALL cover: a=0x1234, b=0 -> done after 17 cycles, product=0, add_a/add_b never change from reset value.
REQ-033 The bench SHALL cover: start pulsed again with a=5, b=5 at cycle 5 of an active 3*4 multiply -> ignored, product=0x0000000C, and the next start yields 0x00000019.
REQ-034 The bench SHALL cover: rst=0 at cycle 8 of a 0xFFFF*0xFFFF multiply -> immediately busy=0, product=0, no done; then 7*9 -> product=0x0000003F.
REQ-035 The bench SHALL cover: back-to-back operation with start held high -> second multiply accepted in the IDLE cycle after DONE, one done pulse per multiply.

Source files
------------

// File: rtl/alu_mult_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier.
// Partial sums go through an external registered 16-bit adder (latency 1, no carry-out).
module alu_mult_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_sum,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [2:0] {StIdle, StEval, StAdd, StWb, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] m_q, m_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] add_a_q, add_a_d;
  logic [15:0] add_b_q, add_b_d;
  logic [31:0] product_q, product_d;
  logic        carry;

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    product_d = product_q;
    carry     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          m_d     = a;
          lo_d    = b;
          hi_d    = 16'h0000;
          cnt_d   = 4'd0;
          state_d = StEval;
        end
      end
      StEval: begin
        if (lo_q[0]) begin
          add_a_d = hi_q;
          add_b_d = m_q;
          state_d = StAdd;
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[15:1]};
          cnt_d        = cnt_q + 4'd1;
          state_d      = (cnt_q == 4'd15) ? StDone : StEval;
        end
      end
      StAdd: state_d = StWb;
      StWb: begin
        // A wrapped 16-bit sum is smaller than either operand: that recovers the lost carry.
        carry        = (add_sum < add_a_q);
        {hi_d, lo_d} = {carry, add_sum, lo_q[15:1]};
        cnt_d        = cnt_q + 4'd1;
        state_d      = (cnt_q == 4'd15) ? StDone : StEval;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Load on entry to DONE so product is already valid while done is high.
    if (state_d == StDone && state_q != StDone) begin
      product_d = {hi_d, lo_d};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      m_q       <= 16'h0000;
      hi_q      <= 16'h0000;
      lo_q      <= 16'h0000;
      cnt_q     <= 4'd0;
      add_a_q   <= 16'h0000;
      add_b_q   <= 16'h0000;
      product_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      product_q <= product_d;
    end
  end

  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq; models the downstream registered adder.
module tb_alu_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum = 16'h0000;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int total = 0;
  int bad   = 0;

  // Results of the last run_mult call.
  int lat_seen;
  int add_changes;
  int carry_seen;

  alu_mult_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_sum (add_sum),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Downstream adder: registered, no reset, wraps at 16 bits.
  always_ff @(posedge clk) add_sum <= add_a + add_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Launch one multiply and wait for done; optionally pulse a second start at cycle inj_cyc.
  task automatic run_mult(input logic [15:0] av, input logic [15:0] bv, input int inj_cyc);
    logic [31:0] prev;
    int n;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    prev  = {add_a, add_b};
    add_changes = 0;
    carry_seen  = 0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      if ({add_a, add_b} != prev) add_changes++;
      prev = {add_a, add_b};
      if (busy && add_sum < add_a) carry_seen++;
      if (n == inj_cyc) begin
        start = 1'b1;
        a     = 16'd5;
        b     = 16'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start    = 1'b0;
    lat_seen = n;
    check("done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int done_cnt;
    int first_done;
    int second_done;

    rst   = 1'b0;
    start = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", product, 32'd0);
    check("rst_add", {add_a, add_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // b=0: no early exit, adder operands untouched
    run_mult(16'h1234, 16'h0000, 0);
    check("b0_latency", lat_seen, 32'd17);
    check("b0_product", product, 32'd0);
    check("b0_add_changes", add_changes, 32'd0);
    check("b0_add_vals", {add_a, add_b}, 32'd0);

    // 3*4: single adder presentation of (0,3)
    run_mult(16'd3, 16'd4, 0);
    check("m3x4_latency", lat_seen, 32'd19);
    check("m3x4_product", product, 32'h0000_000C);
    check("m3x4_add_changes", add_changes, 32'd1);
    check("m3x4_add_vals", {add_a, add_b}, {16'd0, 16'd3});

    // Full-scale operands exercise the recovered carry
    run_mult(16'hFFFF, 16'hFFFF, 0);
    check("max_latency", lat_seen, 32'd49);
    check("max_product", product, 32'hFFFE_0001);
    check("max_carry_seen", {31'd0, carry_seen > 0}, 32'd1);

    // Start while busy is ignored; a/b changed mid-run too
    run_mult(16'd3, 16'd4, 5);
    check("ign_latency", lat_seen, 32'd19);
    check("ign_product", product, 32'h0000_000C);
    run_mult(16'd5, 16'd5, 0);
    check("m5x5_latency", lat_seen, 32'd21);
    check("m5x5_product", product, 32'h0000_0019);

    // Reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_product", product, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 32'd0);
    run_mult(16'd7, 16'd9, 0);
    check("m7x9_latency", lat_seen, 32'd21);
    check("m7x9_product", product, 32'h0000_003F);

    // Back-to-back with start held high: 3*4 then 2*3
    @(negedge clk);
    start = 1'b1;
    a     = 16'd3;
    b     = 16'd4;
    done_cnt    = 0;
    first_done  = 0;
    second_done = 0;
    for (int n = 1; n <= 41; n++) begin
      @(negedge clk);
      if (n == 19) begin
        check("b2b_first_product", product, 32'h0000_000C);
        a = 16'd2;
        b = 16'd3;
      end
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = n;
        else second_done = n;
      end
      if (n == 41) start = 1'b0;
    end
    repeat (4) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("b2b_done_count", done_cnt, 32'd2);
    check("b2b_first_cycle", first_done, 32'd19);
    check("b2b_second_cycle", second_done, 32'd41);
    check("b2b_second_product", product, 32'h0000_0006);
    check("b2b_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
